// File: rtl/fpga_gpu_pkg.sv
// Shared definitions for the FMA datapath: opcodes, instruction field
// positions, line-memory FSM states and sticky error bit indices.
package fpga_gpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'b0000,
        OP_SMA    = 4'b0110,
        OP_LOADI  = 4'b0111,
        OP_LOADB  = 4'b1000,
        OP_WRITEB = 4'b1001,
        OP_FLUSH  = 4'b1110
    } opcode_t;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RA_MSB  = 27;
    localparam int RA_LSB  = 24;
    localparam int IMM_MSB = 23;
    localparam int IMM_LSB = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int RC_MSB  = 3;
    localparam int RC_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUF = 2'd1,
        READ     = 2'd2,
        OUT      = 2'd3
    } state_t;

    localparam int ERR_LOADI_RA      = 0;
    localparam int ERR_BAD_OP        = 1;
    localparam int ERR_PARTIAL_FLUSH = 2;
    localparam int ERR_SMA_RANGE     = 3;

endpackage

// File: rtl/fma_line_memory_line_ram.sv
// Simple dual-port line RAM: one write port, one read port whose data
// passes through READ_LATENCY output registers (BRAM-style, no reset).
module line_ram #(
    parameter int WIDTH        = 96,
    parameter int DEPTH        = 384,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem    [DEPTH];
    logic [WIDTH-1:0] pipe_q [READ_LATENCY];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage 0 is the array read; later stages only shift the captured word.
    always_ff @(posedge clk_in) begin
        if (rd_en) begin
            pipe_q[0] <= mem[rd_addr];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rd_data = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/fma_line_memory.sv
// Instruction-driven line store: stages lines from immediates or the FMA
// write buffer into RAM and streams stored lines back out to the FMAs.
module fma_line_memory
    import fpga_gpu_pkg::*;
#(
    parameter int FMA_COUNT         = 2,
    parameter int WORD_WIDTH        = 16,
    parameter int LINE_WIDTH        = FMA_COUNT * 3 * WORD_WIDTH,
    parameter int DEPTH             = 384,
    parameter int READ_LATENCY      = 2,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid_in,
    output logic                         instr_ready_out,
    input  logic [LINE_WIDTH-1:0]        buffer_data_in,
    input  logic                         buffer_valid_in,
    output logic                         buffer_ready_out,
    output logic [LINE_WIDTH-1:0]        abc_out,
    output logic                         abc_valid_out,
    input  logic                         abc_ready_in,
    output logic                         idle_out,
    output logic [3:0]                   error_out,
    output state_t                       state_out
);

    localparam int WORDS  = FMA_COUNT * 3;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(READ_LATENCY + 1) + 1;

    // Every interface is valid/ready: a transfer happens on the rising edge
    // where both are high; valid never waits on ready, and once abc_valid_out
    // is raised the line stays put until the FMAs take it.

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_inc, sma_addr;
    logic [WORD_WIDTH-1:0] stage_q [WORDS];
    logic [WORDS-1:0]      mask_q;
    logic [3:0]            err_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  incr_q;
    logic [LINE_WIDTH-1:0] abc_q;
    logic                  abc_valid_q;
    logic [LINE_WIDTH-1:0] staging_line, ram_wr_data, rd_data;
    logic                  ram_wr_en, rd_en;

    opcode_t     op;
    logic [3:0]  ra;
    logic [15:0] imm, imm_mod;
    logic        instr_fire, buf_fire, out_fire, read_done;
    logic        loadi_ok, sma_range;
    logic        unused_instr_bits;

    assign op  = opcode_t'(instr_in[OP_MSB:OP_LSB]);
    assign ra  = instr_in[RA_MSB:RA_LSB];
    assign imm = instr_in[IMM_MSB:IMM_LSB];
    assign unused_instr_bits = ^instr_in[RB_MSB:RC_LSB];

    assign instr_fire = instr_valid_in && (state_q == IDLE);
    assign buf_fire   = buffer_valid_in && (state_q == WAIT_BUF);
    assign out_fire   = abc_ready_in && (state_q == OUT);
    assign read_done  = (state_q == READ) && (cnt_q == CNT_W'(READ_LATENCY));

    assign loadi_ok  = int'(ra) < WORDS;
    assign sma_range = int'(imm) >= DEPTH;
    assign imm_mod   = imm % 16'(DEPTH);
    assign sma_addr  = imm_mod[ADDR_W-1:0];
    assign addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

    // Word 0 lands in the most significant slot of the line.
    always_comb begin
        staging_line = '0;
        for (int k = 0; k < WORDS; k++) begin
            staging_line[LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = stage_q[k];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        instr_ready_out  = 1'b0;
        buffer_ready_out = 1'b0;
        ram_wr_en        = 1'b0;
        ram_wr_data      = staging_line;
        case (state_q)
            IDLE: begin
                instr_ready_out = 1'b1;
                if (instr_valid_in) begin
                    case (op)
                        OP_FLUSH:  ram_wr_en = 1'b1;
                        OP_LOADB:  state_d = WAIT_BUF;
                        OP_WRITEB: state_d = READ;
                        default:   state_d = IDLE;
                    endcase
                end
            end
            WAIT_BUF: begin
                buffer_ready_out = buffer_valid_in;
                if (buffer_valid_in) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_data = buffer_data_in;
                    state_d     = IDLE;
                end
            end
            READ: begin
                if (read_done) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (abc_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The read is issued on the WRITEB accept cycle so a write from the
    // previous edge is already in the array.
    assign rd_en = (instr_fire && (op == OP_WRITEB)) || (state_q == READ);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q      <= '0;
            mask_q      <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            incr_q      <= 1'b0;
            abc_q       <= '0;
            abc_valid_q <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            if (instr_fire) begin
                case (op)
                    OP_NOP: ;
                    OP_SMA: begin
                        addr_q <= sma_addr;
                        if (sma_range) err_q[ERR_SMA_RANGE] <= 1'b1;
                    end
                    OP_LOADI: begin
                        if (loadi_ok) begin
                            for (int k = 0; k < WORDS; k++) begin
                                if (ra == 4'(k)) begin
                                    stage_q[k] <= WORD_WIDTH'(imm);
                                    mask_q[k]  <= 1'b1;
                                end
                            end
                        end else begin
                            err_q[ERR_LOADI_RA] <= 1'b1;
                        end
                    end
                    OP_FLUSH: begin
                        if (mask_q != {WORDS{1'b1}}) err_q[ERR_PARTIAL_FLUSH] <= 1'b1;
                        for (int k = 0; k < WORDS; k++) begin
                            stage_q[k] <= '0;
                        end
                        mask_q <= '0;
                        if (ra[0]) addr_q <= addr_inc;
                    end
                    OP_LOADB, OP_WRITEB: begin
                        incr_q <= ra[0];
                        cnt_q  <= '0;
                    end
                    default: err_q[ERR_BAD_OP] <= 1'b1;
                endcase
            end
            if (state_q == READ) begin
                if (read_done) begin
                    abc_q       <= rd_data;
                    abc_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (buf_fire && incr_q) begin
                addr_q <= addr_inc;
            end
            if (out_fire) begin
                abc_valid_q <= 1'b0;
                if (incr_q) addr_q <= addr_inc;
            end
        end
    end

    line_ram #(
        .WIDTH       (LINE_WIDTH),
        .DEPTH       (DEPTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_line_ram (
        .clk_in (clk_in),
        .wr_en  (ram_wr_en),
        .wr_addr(addr_q),
        .wr_data(ram_wr_data),
        .rd_en  (rd_en),
        .rd_addr(addr_q),
        .rd_data(rd_data)
    );

    assign abc_out       = abc_q;
    assign abc_valid_out = abc_valid_q;
    assign idle_out      = (state_q == IDLE);
    assign error_out     = err_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_fma_line_memory.sv
// Directed bench for fma_line_memory: default instance plus a
// 4-FMA / 8-bit / latency-1 instance, with an expected-line scoreboard.
module tb_fma_line_memory;
    import fpga_gpu_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;

    logic [31:0] instr_in = '0;
    logic        instr_valid_in = 1'b0;
    logic        instr_ready_out;
    logic [95:0] buffer_data_in = '0;
    logic        buffer_valid_in = 1'b0;
    logic        buffer_ready_out;
    logic [95:0] abc_out;
    logic        abc_valid_out;
    logic        abc_ready_in = 1'b0;
    logic        idle_out;
    logic [3:0]  error_out;
    state_t      dbg_state;

    logic [31:0] instr_in_p = '0;
    logic        instr_valid_in_p = 1'b0;
    logic        instr_ready_out_p;
    logic [95:0] buffer_data_in_p = '0;
    logic        buffer_valid_in_p = 1'b0;
    logic        buffer_ready_out_p;
    logic [95:0] abc_out_p;
    logic        abc_valid_out_p;
    logic        abc_ready_in_p = 1'b0;
    logic        idle_out_p;
    logic [3:0]  error_out_p;
    state_t      dbg_state_p;

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];

    fma_line_memory dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .instr_in(instr_in), .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .buffer_data_in(buffer_data_in), .buffer_valid_in(buffer_valid_in),
        .buffer_ready_out(buffer_ready_out),
        .abc_out(abc_out), .abc_valid_out(abc_valid_out), .abc_ready_in(abc_ready_in),
        .idle_out(idle_out), .error_out(error_out), .state_out(dbg_state)
    );

    fma_line_memory #(.FMA_COUNT(4), .WORD_WIDTH(8), .READ_LATENCY(1)) dut_p (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .instr_in(instr_in_p), .instr_valid_in(instr_valid_in_p), .instr_ready_out(instr_ready_out_p),
        .buffer_data_in(buffer_data_in_p), .buffer_valid_in(buffer_valid_in_p),
        .buffer_ready_out(buffer_ready_out_p),
        .abc_out(abc_out_p), .abc_valid_out(abc_valid_out_p), .abc_ready_in(abc_ready_in_p),
        .idle_out(idle_out_p), .error_out(error_out_p), .state_out(dbg_state_p)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ra, input logic [15:0] imm);
        return {op, ra, imm, 8'h00};
    endfunction

    // Driver: offer one instruction, returns #1 after its accept edge.
    task automatic issue(input bit sel, input logic [3:0] op, input logic [3:0] ra, input logic [15:0] imm);
        int n;
        if (sel) begin
            instr_in_p = mk(op, ra, imm);
            instr_valid_in_p = 1'b1;
        end else begin
            instr_in = mk(op, ra, imm);
            instr_valid_in = 1'b1;
        end
        n = 0;
        while (!(sel ? instr_ready_out_p : instr_ready_out) && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("issue_ready", sel ? instr_ready_out_p : instr_ready_out, 1'b1);
        @(posedge clk_in); #1;
        instr_valid_in = 1'b0;
        instr_valid_in_p = 1'b0;
    endtask

    // WRITEB, then check latency and data against the scoreboard, stall, release.
    task automatic read_line(input bit sel, input logic [3:0] ra, input logic [95:0] line,
                             input int lat_exp, input int stall);
        int n;
        logic [95:0] exp_line;
        exp_q.push_back(line);
        issue(sel, OP_WRITEB, ra, 16'h0);
        n = 0;
        while (!(sel ? abc_valid_out_p : abc_valid_out) && n < 20) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("rd_latency", n, lat_exp);
        exp_line = exp_q.pop_front();
        check("rd_data", sel ? abc_out_p : abc_out, exp_line);
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk_in); #1; end
            check("stall_valid", sel ? abc_valid_out_p : abc_valid_out, 1'b1);
            check("stall_data", sel ? abc_out_p : abc_out, exp_line);
        end
        if (sel) abc_ready_in_p = 1'b1; else abc_ready_in = 1'b1;
        @(posedge clk_in); #1;
        abc_ready_in = 1'b0;
        abc_ready_in_p = 1'b0;
        check("rd_valid_drop", sel ? abc_valid_out_p : abc_valid_out, 1'b0);
        check("rd_idle", sel ? idle_out_p : idle_out, 1'b1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_abc", abc_out, 96'h0);
        check("rst_abc_valid", abc_valid_out, 1'b0);
        check("rst_buf_ready", buffer_ready_out, 1'b0);
        check("rst_error", error_out, 4'h0);
        check("rst_instr_ready", instr_ready_out, 1'b1);
        check("rst_idle", idle_out, 1'b1);
        #1 rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // Staged write and immediate read-after-write
        issue(0, OP_SMA, 4'd0, 16'd5);
        for (int k = 0; k < 6; k++) issue(0, OP_LOADI, 4'(k), 16'h1111 * 16'(k + 1));
        issue(0, OP_FLUSH, 4'd0, 16'h0);
        read_line(0, 4'd0, 96'h1111_2222_3333_4444_5555_6666, 3, 0);
        check("t1_error", error_out, 4'h0);

        // Buffer load with backpressure on both sides
        issue(0, OP_SMA, 4'd0, 16'd7);
        issue(0, OP_LOADB, 4'd0, 16'h0);
        repeat (4) begin @(posedge clk_in); #1; end
        check("wait_instr_ready", instr_ready_out, 1'b0);
        check("wait_buf_ready", buffer_ready_out, 1'b0);
        buffer_data_in = {12{8'hA5}};
        buffer_valid_in = 1'b1;
        #1;
        check("buf_ready", buffer_ready_out, 1'b1);
        @(posedge clk_in); #1;
        buffer_valid_in = 1'b0;
        check("buf_idle", idle_out, 1'b1);
        read_line(0, 4'd0, {12{8'hA5}}, 3, 5);

        // Auto-increment wrap DEPTH-1 -> 0
        issue(0, OP_SMA, 4'd0, 16'd0);
        for (int k = 0; k < 6; k++) issue(0, OP_LOADI, 4'(k), 16'hB000 + 16'(k));
        issue(0, OP_FLUSH, 4'd0, 16'h0);
        issue(0, OP_SMA, 4'd0, 16'd383);
        for (int k = 0; k < 6; k++) issue(0, OP_LOADI, 4'(k), 16'hC000 + 16'(k));
        issue(0, OP_FLUSH, 4'd1, 16'h0);
        issue(0, OP_SMA, 4'd0, 16'd383);
        read_line(0, 4'd1, 96'hC000_C001_C002_C003_C004_C005, 3, 0);
        read_line(0, 4'd1, 96'hB000_B001_B002_B003_B004_B005, 3, 0);
        check("wrap_error", error_out, 4'h0);

        // Sticky errors
        issue(0, OP_LOADI, 4'd6, 16'hDEAD);
        check("err_loadi_ra", error_out, 4'b0001);
        issue(0, 4'b1111, 4'd0, 16'h0);
        check("err_bad_op", error_out, 4'b0011);
        issue(0, OP_SMA, 4'd0, 16'd10);
        for (int k = 0; k < 3; k++) issue(0, OP_LOADI, 4'(k), 16'h0A01 + 16'(k));
        issue(0, OP_FLUSH, 4'd0, 16'h0);
        check("err_partial", error_out, 4'b0111);
        read_line(0, 4'd0, 96'h0A01_0A02_0A03_0000_0000_0000, 3, 0);
        issue(0, OP_SMA, 4'd0, 16'd500);
        check("err_sma_range", error_out, 4'b1111);
        for (int k = 0; k < 6; k++) issue(0, OP_LOADI, 4'(k), 16'h7000 + 16'(k));
        issue(0, OP_FLUSH, 4'd0, 16'h0);
        issue(0, OP_SMA, 4'd0, 16'd116);
        read_line(0, 4'd0, 96'h7000_7001_7002_7003_7004_7005, 3, 0);

        // Reset in the middle of a read
        issue(0, OP_WRITEB, 4'd0, 16'h0);
        check("pre_rst_state", dbg_state, READ);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_valid", abc_valid_out, 1'b0);
        check("mid_rst_idle", idle_out, 1'b1);
        check("mid_rst_ready", instr_ready_out, 1'b1);
        check("mid_rst_error", error_out, 4'h0);
        #2 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        for (int k = 0; k < 6; k++) issue(0, OP_LOADI, 4'(k), 16'h3C00 + 16'(k));
        issue(0, OP_FLUSH, 4'd0, 16'h0);
        read_line(0, 4'd0, 96'h3C00_3C01_3C02_3C03_3C04_3C05, 3, 0);

        // Parameter sweep instance: 12 x 8-bit words, read latency 1
        issue(1, OP_SMA, 4'd0, 16'd3);
        for (int k = 0; k < 12; k++) issue(1, OP_LOADI, 4'(k), 16'h0010 + 16'(k));
        issue(1, OP_FLUSH, 4'd1, 16'h0);
        check("p_error_clean", error_out_p, 4'h0);
        issue(1, OP_SMA, 4'd0, 16'd3);
        read_line(1, 4'd0, 96'h10_11_12_13_14_15_16_17_18_19_1A_1B, 2, 2);
        issue(1, OP_LOADI, 4'd12, 16'h00FF);
        check("p_err_loadi_ra", error_out_p, 4'b0001);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
